// File: rtl/imem_loader.sv
// Boot loader: parses a header/payload/checksum byte stream and writes little-endian words into the instruction SRAM.
// One byte per cycle at most, one bubble per word (WRITE); CPU_HOLD stays high until a verified image is in place.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  START,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic                  MEM_CEN,
  output logic                  MEM_WEN,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [DATA_WIDTH-1:0] MEM_D,
  output logic                  CPU_HOLD,
  output logic                  DONE,
  output logic                  ERROR
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  state_t                r_state, w_next;
  logic [2:0]            r_idx;
  logic [15:0]           r_cnt, r_base, r_rem;
  logic [ADDR_WIDTH-1:0] r_addr, r_mem_a;
  logic [DATA_WIDTH-1:0] r_word, r_mem_d;
  logic [7:0]            r_chk;
  logic                  w_ready, w_xfer, w_range_err;
  logic [16:0]           w_end;

  // 17-bit sum so BASE+CNT cannot wrap past the end of the SRAM
  assign w_end       = {1'b0, r_base} + {1'b0, r_cnt};
  assign w_range_err = ({1'b0, r_base} >= DEPTH17) || (w_end > DEPTH17);

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_HDR:         w_ready = (r_idx != 3'd4);
      S_DATA, S_CHK: w_ready = 1'b1;
      default:       w_ready = 1'b0;
    endcase
  end

  assign w_xfer = w_ready && BYTE_VALID;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (START) w_next = S_HDR;
      S_HDR: begin
        // idx==4 is the dedicated range-check cycle after the last header byte
        if (r_idx == 3'd4) begin
          if (w_range_err)        w_next = S_ERR;
          else if (r_cnt == 16'd0) w_next = S_CHK;
          else                    w_next = S_DATA;
        end
      end
      S_DATA:  if (w_xfer && r_idx == 3'd3) w_next = S_WRITE;
      S_WRITE: w_next = (r_rem == 16'd1) ? S_CHK : S_DATA;
      S_CHK:   if (w_xfer) w_next = (BYTE_IN == r_chk) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_rem   <= '0;
      r_addr  <= '0;
      r_mem_a <= '0;
      r_word  <= '0;
      r_mem_d <= '0;
      r_chk   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            r_idx <= '0;
            r_chk <= '0;
          end
        end
        S_HDR: begin
          if (r_idx == 3'd4) begin
            r_idx  <= '0;
            r_addr <= r_base[ADDR_WIDTH-1:0];
            r_rem  <= r_cnt;
          end else if (w_xfer) begin
            case (r_idx)
              3'd0:    r_cnt[7:0]   <= BYTE_IN;
              3'd1:    r_cnt[15:8]  <= BYTE_IN;
              3'd2:    r_base[7:0]  <= BYTE_IN;
              default: r_base[15:8] <= BYTE_IN;
            endcase
            r_idx <= r_idx + 3'd1;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= {BYTE_IN, r_word[DATA_WIDTH-1:8]};
            r_chk  <= r_chk ^ BYTE_IN;
            if (r_idx == 3'd3) begin
              r_idx   <= '0;
              r_mem_a <= r_addr;
              r_mem_d <= {BYTE_IN, r_word[DATA_WIDTH-1:8]};
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign BYTE_READY = w_ready;
  assign MEM_CEN    = (r_state != S_WRITE);
  assign MEM_WEN    = (r_state != S_WRITE);
  assign MEM_A      = r_mem_a;
  assign MEM_D      = r_mem_d;
  assign CPU_HOLD   = (r_state != S_DONE);
  assign DONE       = (r_state == S_DONE);
  assign ERROR      = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams images with random valid gaps and checks writes and status against a reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        START;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        MEM_CEN, MEM_WEN;
  logic [10:0] MEM_A;
  logic [31:0] MEM_D;
  logic        CPU_HOLD, DONE, ERROR;

  imem_loader dut (
    .clk(clk), .rst(rst), .START(START),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .MEM_CEN(MEM_CEN), .MEM_WEN(MEM_WEN), .MEM_A(MEM_A), .MEM_D(MEM_D),
    .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] g_words[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: each low-strobe cycle is one SRAM write
  always @(negedge clk) begin
    if (!rst && !MEM_CEN && !MEM_WEN) begin
      q_addr.push_back(MEM_A);
      q_data.push_back(MEM_D);
      check_eq("ready_in_write", {63'd0, BYTE_READY}, 64'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic hs;
    repeat ($urandom_range(0, 2)) begin
      BYTE_VALID = 1'b0;
      BYTE_IN    = 8'($urandom);
      tick();
    end
    BYTE_VALID = 1'b1;
    BYTE_IN    = b;
    hs = 1'b0;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = BYTE_READY;
      tick();
    end
    if (!hs) check_eq("byte_timeout", 64'd1, 64'd0);
    BYTE_VALID = 1'b0;
  endtask

  task automatic pulse_start;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    g_words.delete();
    for (int i = 0; i < n; i++) g_words.push_back($urandom);
  endtask

  task automatic send_header(input logic [15:0] cnt, input logic [15:0] base);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    send_byte(base[7:0]);
    send_byte(base[15:8]);
  endtask

  // Reference model: range rule on the header, consecutive writes from BASE, XOR of payload bytes
  task automatic do_load(input logic [15:0] cnt, input logic [15:0] base, input logic [7:0] chk_flip);
    logic        exp_range;
    logic [7:0]  x;
    logic [31:0] w;
    logic [16:0] top;
    top       = {1'b0, base} + {1'b0, cnt};
    exp_range = (base >= 16'd2048) || (top > 17'd2048);
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_header(cnt, base);
    if (exp_range) begin
      tick();
      check_eq("range_error", {63'd0, ERROR}, 64'd1);
      check_eq("range_ready", {63'd0, BYTE_READY}, 64'd0);
      check_eq("range_hold", {63'd0, CPU_HOLD}, 64'd1);
      check_eq("range_writes", 64'(q_addr.size()), 64'd0);
      return;
    end
    x = 8'h00;
    for (int i = 0; i < int'(cnt); i++) begin
      w = g_words[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    send_byte(x ^ chk_flip);
    for (int n = 0; n < 50 && !(DONE || ERROR); n++) tick();
    check_eq("done", {63'd0, DONE}, {63'd0, chk_flip == 8'h00});
    check_eq("error", {63'd0, ERROR}, {63'd0, chk_flip != 8'h00});
    check_eq("hold", {63'd0, CPU_HOLD}, {63'd0, chk_flip != 8'h00});
    check_eq("write_count", 64'(q_addr.size()), 64'(cnt));
    for (int i = 0; i < int'(cnt) && i < q_addr.size(); i++) begin
      check_eq("write_addr", 64'(q_addr[i]), 64'(base + 16'(i)));
      check_eq("write_data", 64'(q_data[i]), 64'(g_words[i]));
    end
  endtask

  task automatic check_reset_vals;
    check_eq("rst_ready", {63'd0, BYTE_READY}, 64'd0);
    check_eq("rst_cen", {63'd0, MEM_CEN}, 64'd1);
    check_eq("rst_wen", {63'd0, MEM_WEN}, 64'd1);
    check_eq("rst_a", 64'(MEM_A), 64'd0);
    check_eq("rst_d", 64'(MEM_D), 64'd0);
    check_eq("rst_hold", {63'd0, CPU_HOLD}, 64'd1);
    check_eq("rst_done", {63'd0, DONE}, 64'd0);
    check_eq("rst_error", {63'd0, ERROR}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    START      = 1'b0;
    BYTE_IN    = 8'h00;
    BYTE_VALID = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    g_words.delete();
    g_words.push_back(32'h0000_0013);
    g_words.push_back(32'h0020_80B3);
    do_load(16'd2, 16'h0010, 8'h00);

    do_load(16'd2, 16'h07FF, 8'h00);
    do_load(16'd0, 16'h0800, 8'h00);
    fill_rand(2);
    do_load(16'd2, 16'h07FE, 8'h00);

    fill_rand(1);
    do_load(16'd1, 16'(($urandom_range(0, 2047))), 8'h5A);
    fill_rand(2);
    do_load(16'd2, 16'h0300, 8'h00);

    do_load(16'd0, 16'h0000, 8'h00);
    do_load(16'd0, 16'h0000, 8'h01);

    for (int t = 0; t < 10; t++) begin
      logic [15:0] c, bs;
      c  = 16'($urandom_range(1, 5));
      bs = 16'($urandom_range(0, 2060));
      fill_rand(int'(c));
      do_load(c, bs, ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(1, 255))) : 8'h00);
    end

    pulse_start();
    send_header(16'd2, 16'h0020);
    send_byte(8'hAA);
    send_byte(8'h55);
    rst = 1'b1;
    tick();
    check_reset_vals();
    rst = 1'b0;
    tick();
    fill_rand(3);
    do_load(16'd3, 16'h0100, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
